// File: rtl/pipelined_multiplier_if.sv
// Issue/result bundle of the pipelined multiplier: operands, opcode and tag in,
// tagged result out, valid/ready on both sides plus a pipeline-wide flush.
interface pipelined_multiplier_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [1:0]       opcode_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_i;
    logic             ready_o;
    logic             flush_i;
    logic [WIDTH-1:0] result_o;
    logic [TAG_W-1:0] tag_o;
    logic             vld_o;
    logic             ready_i;

    modport slave (
        input  a_i, b_i, opcode_i, tag_i, valid_i, flush_i, ready_i,
        output ready_o, result_o, tag_o, vld_o
    );

    modport master (
        output a_i, b_i, opcode_i, tag_i, valid_i, flush_i, ready_i,
        input  ready_o, result_o, tag_o, vld_o
    );
endinterface

// File: rtl/pipelined_multiplier.sv
// RISC-V MUL/MULH/MULHSU/MULHU, one op per cycle, STAGES cycles accept-to-result.
// A held output (vld_o & ~ready_i) freezes the whole pipe; flush kills every valid bit.
module pipelined_multiplier #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 6
) (
    input logic                   clk_i,
    input logic                   rst_i,
    pipelined_multiplier_if.slave mif
);
    localparam int PW = 2 * WIDTH;

    logic              stall;
    logic              adv;
    logic              a_sx;
    logic              b_sx;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [STAGES-2:0] hi_q, hi_d;
    logic [WIDTH:0]    a_q, a_d;
    logic [WIDTH:0]    b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [PW-1:0]     prod_c;
    logic [PW-1:0]     prod_last;

    assign stall = vld_q[STAGES-1] & ~mif.ready_i;
    assign adv   = ~stall;
    assign a_sx  = (mif.opcode_i != 2'b11) & mif.a_i[WIDTH-1];
    assign b_sx  = ~mif.opcode_i[1] & mif.b_i[WIDTH-1];

    // Extending the (WIDTH+1)-bit operands to 2*WIDTH keeps the low 2*WIDTH product bits exact.
    assign prod_c = {{(WIDTH-1){a_q[WIDTH]}}, a_q} * {{(WIDTH-1){b_q[WIDTH]}}, b_q};

    if (STAGES == 2) begin : g_direct
        assign prod_last = prod_c;
    end else begin : g_mid
        logic [PW-1:0] mid_q [STAGES-2];
        logic [PW-1:0] mid_d [STAGES-2];

        always_comb begin
            mid_d = mid_q;
            if (adv) begin
                mid_d[0] = prod_c;
                for (int i = 1; i < STAGES - 2; i++) mid_d[i] = mid_q[i-1];
            end
        end

        always_ff @(posedge clk_i) mid_q <= mid_d;

        assign prod_last = mid_q[STAGES-3];
    end

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        hi_d  = hi_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        if (adv) begin
            vld_d[0] = mif.valid_i;
            tag_d[0] = mif.tag_i;
            hi_d[0]  = |mif.opcode_i;
            a_d      = {a_sx, mif.a_i};
            b_d      = {b_sx, mif.b_i};
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
            for (int i = 1; i < STAGES - 1; i++) hi_d[i] = hi_q[i-1];
            res_d = hi_q[STAGES-2] ? prod_last[PW-1:WIDTH] : prod_last[WIDTH-1:0];
        end
        // An output handshake in the flush cycle still completes: the consumer saw it.
        if (mif.flush_i) vld_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            res_q <= '0;
            for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            res_q <= res_d;
            tag_q <= tag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        hi_q <= hi_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign mif.ready_o  = adv & ~rst_i;
    assign mif.vld_o    = vld_q[STAGES-1];
    assign mif.result_o = res_q;
    assign mif.tag_o    = tag_q[STAGES-1];
endmodule

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Parametrised, fully pipelined integer multiplier for the memory-system execution cluster. It implements the four RISC-V M-extension multiply flavours (MUL, MULH, MULHSU, MULHU) for a configurable operand width and pipeline depth. It accepts one operation per cycle and carries an opaque tag for writeback routing. It supports output backpressure and a pipeline-wide flush for mispredict or exception recovery.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits; ≥ 8.
- STAGES, 3: accept-to-result latency in cycles; ≥ 2.
- TAG_W, 6: width of the pass-through tag.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- a_i  in  WIDTH  operand rs1.
- b_i  in  WIDTH  operand rs2.
- opcode_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- tag_i  in  TAG_W  tag returned with the result.
- valid_i  in  1  operation offered.
- ready_o  out  1  operation accepted this cycle when valid_i & ready_o.
- flush_i  in  1  kill every in-flight operation.
- result_o  out  WIDTH  result.
- tag_o  out  TAG_W  tag of result_o.
- vld_o  out  1  result_o/tag_o valid.
- ready_i  in  1  consumer accepts the result this cycle when vld_o & ready_i.

## Operation
- Pipeline: STAGES register slots. Each slot holds a valid bit, a tag, an opcode, and partial data.
  - Slot 1 captures the operands.
  - Slot STAGES is the output register that drives result_o, tag_o and vld_o.
  - The multiply may be split or retimed freely across slots 1..STAGES-1. The latency must be exactly STAGES.
- Arithmetic: form a 2·WIDTH product of (WIDTH+1)-bit extended operands.
  - a is sign-extended for opcodes 00, 01 and 10; zero-extended for 11.
  - b is sign-extended for opcodes 00 and 01; zero-extended for 10 and 11.
  - Opcode 00 returns product[WIDTH-1:0]. All other opcodes return product[2·WIDTH-1:WIDTH].
  - No overflow flag. The most-negative operand is handled exactly, with no saturation.
- Stall: stall = vld_o & ~ready_i. While stalled, every slot holds its contents, including its valid bit.
- Bubbles are not compressed. A stall freezes the whole pipe. The upstream sees ready_o = ~stall & ~rst_i.
- Flush: when flush_i = 1, every valid bit (including vld_o) clears at the next edge.
  - An operation offered in the same cycle is dropped, even if valid_i & ready_o.
  - Flush overrides stall.
  - ready_o is not gated by flush_i.
- Data and tag registers need not be cleared by flush. Only valid bits are architecturally visible.
- Reset: all valid bits clear; vld_o = 0, result_o = 0, tag_o = 0. ready_o = 0 while rst_i = 1 and 1 in the first cycle after.
- Reset mid-operation discards everything in flight. No result from before reset may ever appear.

## Timing
- An operation accepted at edge N (valid_i & ready_o) shows vld_o = 1 in the cycle after edge N+STAGES-1. With no stall, that is STAGES edges from acceptance to vld_o.
- Throughput is one operation per cycle with ready_i held high. Results appear in acceptance order with no reordering.
- While vld_o & ~ready_i, result_o and tag_o are stable.
- The cycle ready_i rises, the pipe advances at that edge.
- Outputs are registered. Only ready_o is combinational, from ready_i, vld_o and rst_i.
- Simultaneous flush_i and ready_i: the handshake at the output completes (the consumer saw it). All remaining slots are killed.

## Test plan
- WIDTH=32, STAGES=3, opcode 00, a=7, b=0xFFFFFFFD, tag 0x05 -> after 3 cycles vld_o=1, result_o=0xFFFFFFEB, tag_o=0x05.
- Back-to-back, one per cycle: MULH 0x80000000×0x80000000 -> 0x40000000; MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - Required: consecutive vld_o, in order, with tags intact.
- Backpressure: 4 ops issued, ready_i held low for 5 cycles starting when the first result appears -> ready_o=0 during the stall, result_o/tag_o frozen. After release, all 4 results arrive in order; none lost or duplicated.
- Flush: 3 ops in flight, plus a 4th offered in the flush cycle -> vld_o=0 for the next STAGES cycles. A new op issued the cycle after the flush returns its correct result at normal latency.
- Reset mid-operation: rst_i asserted for 1 cycle with 2 ops in flight -> vld_o=0 and result_o=0 afterwards. No stale result ever appears.
- Parameter sweep: WIDTH=16, STAGES=2, MULHSU a=0x8000, b=0xFFFF -> result_o=0x8000. Also a randomized 10k-op sweep against a reference model for each opcode, with random ready_i and flush_i.
